// File: rtl/inst_fetch.sv
// Instruction-fetch producer: owns the PC, issues req/ack fetches and presents
// words to the IF/ID register through a one-entry skid buffer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | one cycle after reset release, no request
// S_REQ   | request at r_pc outstanding; ack fills output slot or buffer
// S_WAIT  | buffer full, no request; waiting for output to be consumed
// S_DRAIN | squashed request still outstanding at r_drain_addr; drop data
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_jmp,
   input  logic [31:0] i_jmp_addr,
   input  logic        i_if_stall,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_inst_addr_from_if,
   output logic [31:0] o_inst_from_if,
   output logic        o_inst_valid
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_drain_addr;
   logic        r_out_valid;
   logic [31:0] r_out_addr;
   logic [31:0] r_out_inst;
   logic        r_buf_valid;
   logic [31:0] r_buf_addr;
   logic [31:0] r_buf_inst;

   logic        w_consume;
   logic        w_slot_free;
   logic [31:0] w_pc_next;

   assign w_consume   = r_out_valid & ~i_if_stall;
   assign w_slot_free = ~r_out_valid | ~i_if_stall;
   assign w_pc_next   = r_pc + 32'd4;

   assign o_imem_req          = (r_state == S_REQ) || (r_state == S_DRAIN);
   assign o_imem_addr         = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
   assign o_inst_valid        = r_out_valid;
   assign o_inst_addr_from_if = r_out_addr;
   assign o_inst_from_if      = r_out_valid ? r_out_inst : NOP_INST;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_drain_addr <= RESET_PC;
         r_out_valid  <= 1'b0;
         r_out_addr   <= 32'd0;
         r_out_inst   <= NOP_INST;
         r_buf_valid  <= 1'b0;
         r_buf_addr   <= 32'd0;
         r_buf_inst   <= NOP_INST;
      end else if (i_jmp) begin
         r_pc        <= {i_jmp_addr[31:2], 2'b00};
         r_out_valid <= 1'b0;
         r_out_inst  <= NOP_INST;
         r_buf_valid <= 1'b0;
         case (r_state)
            S_REQ: begin
               // An unanswered request must still be retired before the new PC goes out.
               if (!i_imem_ack) begin
                  r_state      <= S_DRAIN;
                  r_drain_addr <= r_pc;
               end else begin
                  r_state <= S_REQ;
               end
            end
            S_DRAIN: r_state <= S_DRAIN;
            default: r_state <= S_REQ;
         endcase
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_REQ;
            S_REQ: begin
               if (i_imem_ack) begin
                  r_pc <= w_pc_next;
                  if (w_slot_free) begin
                     r_out_valid <= 1'b1;
                     r_out_addr  <= r_pc;
                     r_out_inst  <= i_imem_rdata;
                  end else begin
                     r_buf_valid <= 1'b1;
                     r_buf_addr  <= r_pc;
                     r_buf_inst  <= i_imem_rdata;
                     r_state     <= S_WAIT;
                  end
               end else if (w_consume) begin
                  r_out_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (w_consume) begin
                  r_out_valid <= r_buf_valid;
                  r_out_addr  <= r_buf_addr;
                  r_out_inst  <= r_buf_inst;
                  r_buf_valid <= 1'b0;
                  r_state     <= S_REQ;
               end
            end
            S_DRAIN: begin
               if (w_consume) r_out_valid <= 1'b0;
               if (i_imem_ack) r_state <= S_REQ;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then randomized latency/stall/jmp traffic,
// checked against an in-order delivery model with a per-address memory image.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, jmp, stall, ack;
   logic [31:0] jmp_addr, rdata;
   logic        o_imem_req, o_inst_valid;
   logic [31:0] o_imem_addr, o_inst_addr_from_if, o_inst_from_if;

   int checks = 0, failures = 0, delivered = 0;
   int wait_cnt = 0, cur_lat = 0, lat_lo = 0, lat_hi = 0;
   bit spur_en = 1'b0;
   logic [31:0] exp_pc;
   logic        prev_req = 1'b0, prev_ack = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
      .i_clk(clk), .i_rst(rst), .i_jmp(jmp), .i_jmp_addr(jmp_addr), .i_if_stall(stall),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ack(ack),
      .i_imem_rdata(rdata), .o_inst_addr_from_if(o_inst_addr_from_if),
      .o_inst_from_if(o_inst_from_if), .o_inst_valid(o_inst_valid));

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; drives one cycle of stimulus and checks the model.
   task automatic cycle(input logic j, input logic [31:0] ja, input logic s);
      logic        pv, rq;
      logic [31:0] pa, pi, ra;
      pv = o_inst_valid; pa = o_inst_addr_from_if; pi = o_inst_from_if;
      rq = o_imem_req;   ra = o_imem_addr;
      if (prev_req && !prev_ack && rq) chk("addr_stable", ra, prev_addr);
      if (!pv) chk("bubble_nop", pi, NOP);
      if (rq) ack = (wait_cnt >= cur_lat);
      else    ack = spur_en && ($urandom_range(0, 3) == 0);
      rdata = rq ? mem_word(ra) : 32'hDEAD_BEEF;
      jmp = j; jmp_addr = ja; stall = s;
      if (pv && !s) begin
         chk("deliv_addr", pa, exp_pc);
         chk("deliv_inst", pi, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         delivered++;
      end
      if (j) exp_pc = {ja[31:2], 2'b00};
      @(posedge clk); #1;
      if (j) begin
         chk("jmp_squash_valid", o_inst_valid, 0);
      end else if (pv && s) begin
         chk("stall_hold_valid", o_inst_valid, 1);
         chk("stall_hold_addr", o_inst_addr_from_if, pa);
         chk("stall_hold_inst", o_inst_from_if, pi);
      end
      prev_req = rq; prev_ack = ack; prev_addr = ra;
      if (rq && ack) begin
         wait_cnt = 0;
         cur_lat = $urandom_range(lat_lo, lat_hi);
      end else if (rq) wait_cnt++;
      else wait_cnt = 0;
      @(negedge clk);
   endtask

   initial begin
      int d0;
      rst = 1'b1; jmp = 1'b0; stall = 1'b0; ack = 1'b0; jmp_addr = 32'd0; rdata = 32'd0;
      exp_pc = RESET_PC;
      repeat (2) @(negedge clk);
      chk("rst_req", o_imem_req, 0);
      chk("rst_imem_addr", o_imem_addr, RESET_PC);
      chk("rst_valid", o_inst_valid, 0);
      chk("rst_inst_addr", o_inst_addr_from_if, 0);
      chk("rst_inst", o_inst_from_if, NOP);

      // 1: zero-wait streaming
      rst = 1'b0;
      chk("t1_idle_req", o_imem_req, 0);
      @(negedge clk);
      chk("t1_req", o_imem_req, 1);
      chk("t1_addr0", o_imem_addr, 32'h0);
      cycle(0, 0, 0);
      chk("t1_addr4", o_imem_addr, 32'h4);
      chk("t1_valid", o_inst_valid, 1);
      chk("t1_out0", o_inst_addr_from_if, 32'h0);
      cycle(0, 0, 0);
      chk("t1_addr8", o_imem_addr, 32'h8);
      chk("t1_out4", o_inst_addr_from_if, 32'h4);
      cycle(0, 0, 0);
      chk("t1_out8", o_inst_addr_from_if, 32'h8);

      // 2: stall with skid buffer
      cycle(0, 0, 1);
      chk("t2_req_off", o_imem_req, 0);
      chk("t2_hold8", o_inst_addr_from_if, 32'h8);
      cycle(0, 0, 1);
      cycle(0, 0, 1);
      chk("t2_req_off2", o_imem_req, 0);
      cycle(0, 0, 0);
      chk("t2_outC", o_inst_addr_from_if, 32'hC);
      chk("t2_req_on", o_imem_req, 1);
      chk("t2_addr10", o_imem_addr, 32'h10);

      // 3: jmp during outstanding request, latency 2
      cur_lat = 2; lat_lo = 2; lat_hi = 2;
      cycle(0, 0, 0);
      cycle(1, 32'h0000_0103, 0);
      chk("t3_drain_req", o_imem_req, 1);
      chk("t3_drain_addr", o_imem_addr, 32'h10);
      cycle(0, 0, 0);
      chk("t3_new_addr", o_imem_addr, 32'h100);
      chk("t3_bubble", o_inst_valid, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      chk("t3_still_bubble", o_inst_valid, 0);
      cycle(0, 0, 0);
      chk("t3_valid", o_inst_valid, 1);
      chk("t3_out100", o_inst_addr_from_if, 32'h100);

      // 4: jmp coincident with ack
      cur_lat = 0; lat_lo = 0; lat_hi = 0;
      cycle(1, 32'h0000_0200, 0);
      chk("t4_req", o_imem_req, 1);
      chk("t4_addr", o_imem_addr, 32'h200);
      chk("t4_bubble", o_inst_valid, 0);

      // 5: PC wrap
      cycle(1, 32'hFFFF_FFFC, 0);
      cycle(0, 0, 0);
      chk("t5_out_top", o_inst_addr_from_if, 32'hFFFF_FFFC);
      cycle(0, 0, 0);
      chk("t5_out_wrap", o_inst_addr_from_if, 32'h0);
      chk("t5_addr4", o_imem_addr, 32'h4);

      // randomized traffic
      lat_lo = 0; lat_hi = 3; spur_en = 1'b1;
      for (int k = 0; k < 3000; k++)
         cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 2) == 0);
      d0 = delivered;
      for (int k = 0; k < 60 && delivered < d0 + 5; k++) cycle(0, 0, 0);
      chk("progress", 32'(delivered >= d0 + 5), 1);
      chk("total_delivered", 32'(delivered > 300), 1);

      // 6: reset during a pending request, late ack ignored
      cur_lat = 1000; lat_lo = 1000; lat_hi = 1000; spur_en = 1'b0;
      cycle(1, 32'h0000_0040, 0);
      cycle(0, 0, 0);
      chk("t6_pending", o_imem_req, 1);
      rst = 1'b1; ack = 1'b1; jmp = 1'b0; stall = 1'b0;
      #1;
      chk("t6_rst_req", o_imem_req, 0);
      chk("t6_rst_addr", o_imem_addr, RESET_PC);
      chk("t6_rst_valid", o_inst_valid, 0);
      chk("t6_rst_inst", o_inst_from_if, NOP);
      chk("t6_rst_iaddr", o_inst_addr_from_if, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("t6_late_ack", o_inst_valid, 0);
      chk("t6_first_addr", o_imem_addr, RESET_PC);
      @(negedge clk);
      exp_pc = RESET_PC; wait_cnt = 0; cur_lat = 1; lat_lo = 0; lat_hi = 2;
      prev_req = 1'b0; prev_ack = 1'b0;
      d0 = delivered;
      for (int k = 0; k < 40; k++) cycle(0, 0, $urandom_range(0, 3) == 0);
      chk("t6_progress", 32'(delivered > d0), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
